// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the in-order WB stage (A)
// and the long-latency unit (B), each with a one-entry holding buffer.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        A_Valid,
  input  logic [4:0]  A_Reg,
  input  logic [31:0] A_Data,
  output logic        A_Ready,
  input  logic        B_Valid,
  input  logic [4:0]  B_Reg,
  input  logic [31:0] B_Data,
  output logic        B_Ready,
  output logic        Write1,
  output logic [4:0]  WriteReg1,
  output logic [31:0] WriteData1,
  output logic [31:0] PendMask
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  function automatic logic [31:0] oneHot(input logic [4:0] idx);
    oneHot = 32'd1 << idx;
  endfunction

  logic        fullA_r, fullB_r;
  logic        olderA_r, olderB_r;
  logic [4:0]  regA_r, regB_r;
  logic [31:0] dataA_r, dataB_r;
  logic [2:0]  starveCnt_r;

  logic        grantA_s, grantB_s;
  logic        accA_s, accB_s;
  logic        olderANext_s, olderBNext_s;
  logic [2:0]  starveNext_s;

  // Grant selection from buffer state only; same-register entries always drain oldest first.
  always_comb begin
    grantA_s = 1'b0;
    grantB_s = 1'b0;
    if (fullA_r && !fullB_r) begin
      grantA_s = 1'b1;
    end else if (!fullA_r && fullB_r) begin
      grantB_s = 1'b1;
    end else if (fullA_r && fullB_r) begin
      if (regA_r == regB_r) begin
        if (olderB_r && !olderA_r) begin
          grantB_s = 1'b1;
        end else begin
          grantA_s = 1'b1;
        end
      end else if (starveCnt_r == STARVE_MAX) begin
        grantB_s = 1'b1;
      end else begin
        grantA_s = 1'b1;
      end
    end else begin
      grantA_s = 1'b0;
      grantB_s = 1'b0;
    end
  end

  // Handshake: a buffer can take a new entry when empty or draining this cycle.
  always_comb begin
    A_Ready = RESET && (!fullA_r || grantA_s);
    B_Ready = RESET && (!fullB_r || grantB_s);
    accA_s  = A_Valid && A_Ready && (A_Reg != 5'd0);
    accB_s  = B_Valid && B_Ready && (B_Reg != 5'd0);
  end

  // Relative age of the two entries and the starvation counter for B.
  always_comb begin
    olderANext_s = grantA_s ? 1'b0 : olderA_r;
    olderBNext_s = grantB_s ? 1'b0 : olderB_r;
    if (accA_s && accB_s) begin
      olderANext_s = 1'b0;
      olderBNext_s = 1'b1;
    end else if (accA_s) begin
      olderANext_s = 1'b0;
      if (fullB_r && !grantB_s) begin
        olderBNext_s = 1'b1;
      end else begin
        olderBNext_s = 1'b0;
      end
    end else if (accB_s) begin
      olderBNext_s = 1'b0;
      if (fullA_r && !grantA_s) begin
        olderANext_s = 1'b1;
      end else begin
        olderANext_s = 1'b0;
      end
    end else begin
      olderANext_s = olderANext_s;
      olderBNext_s = olderBNext_s;
    end

    if (fullB_r && !grantB_s) begin
      if (starveCnt_r == STARVE_MAX) begin
        starveNext_s = starveCnt_r;
      end else begin
        starveNext_s = starveCnt_r + 3'd1;
      end
    end else begin
      starveNext_s = 3'd0;
    end
  end

  // In-flight destinations: both buffers plus the entry currently on the write port.
  always_comb begin
    PendMask = 32'd0;
    if (fullA_r) begin
      PendMask = PendMask | oneHot(regA_r);
    end else begin
      PendMask = PendMask;
    end
    if (fullB_r) begin
      PendMask = PendMask | oneHot(regB_r);
    end else begin
      PendMask = PendMask;
    end
    if (Write1) begin
      PendMask = PendMask | oneHot(WriteReg1);
    end else begin
      PendMask = PendMask;
    end
  end

  // Buffer, age, starvation and write-port state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fullA_r     <= 1'b0;
      fullB_r     <= 1'b0;
      olderA_r    <= 1'b0;
      olderB_r    <= 1'b0;
      regA_r      <= 5'd0;
      regB_r      <= 5'd0;
      dataA_r     <= 32'd0;
      dataB_r     <= 32'd0;
      starveCnt_r <= 3'd0;
      Write1      <= 1'b0;
      WriteReg1   <= 5'd0;
      WriteData1  <= 32'd0;
    end else begin
      if (accA_s) begin
        fullA_r <= 1'b1;
        regA_r  <= A_Reg;
        dataA_r <= A_Data;
      end else if (grantA_s) begin
        fullA_r <= 1'b0;
      end
      if (accB_s) begin
        fullB_r <= 1'b1;
        regB_r  <= B_Reg;
        dataB_r <= B_Data;
      end else if (grantB_s) begin
        fullB_r <= 1'b0;
      end
      olderA_r    <= olderANext_s;
      olderB_r    <= olderBNext_s;
      starveCnt_r <= starveNext_s;
      if (grantA_s) begin
        Write1     <= 1'b1;
        WriteReg1  <= regA_r;
        WriteData1 <= dataA_r;
      end else if (grantB_s) begin
        Write1     <= 1'b1;
        WriteReg1  <= regB_r;
        WriteData1 <= dataB_r;
      end else begin
        Write1     <= 1'b0;
      end
    end
  end

endmodule
